// File: rtl/pe_operand_feeder.sv
// Edge feeder for one systolic PE lane: buffers (x, w) operand pairs, issues them
// with the PE start/stall handshake, counts results and returns the final psum.
module pe_operand_feeder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned KW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [KW-1:0] cfg_k,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_x,
   input  logic [31:0]   in_w,
   output logic [31:0]   pe_x,
   output logic [31:0]   pe_w,
   output logic          pe_start,
   input  logic          pe_stall,
   input  logic          pe_data_ready,
   input  logic [31:0]   pe_psum,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_psum,
   output logic          busy,
   output logic          done
);
   localparam int unsigned WW = 32;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2*WW-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [KW-1:0]   k;
   logic [KW-1:0]   issued;
   logic [KW-1:0]   returned;
   logic            full;
   logic            empty;
   logic            push;
   logic            issue;
   logic            job_start;
   logic            dr_seen;
   logic            last_issue;
   logic            last_return;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && !full;

   assign pe_x     = mem[rd_ptr][2*WW-1:WW];
   assign pe_w     = mem[rd_ptr][WW-1:0];
   assign pe_start = (state == FEED) && !empty && (issued < k);
   assign issue    = pe_start && !pe_stall;

   assign job_start   = (state == IDLE) && start;
   assign dr_seen     = pe_data_ready && ((state == FEED) || (state == DRAIN));
   assign last_issue  = issue && ((issued + KW'(1)) == k);
   assign last_return = dr_seen && ((returned + KW'(1)) == k);

   assign out_valid = (state == OUT);
   assign busy      = (state != IDLE);
   assign done      = (state == OUT) && out_ready;

   // Operand storage; no bypass, so a fresh push is visible at the head next cycle.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_x, in_w};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (issue) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, issue})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: final issue and final result may coincide, which skips DRAIN.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (cfg_k == '0) ? OUT : FEED;
            end
         end
         FEED: begin
            if (last_issue) begin
               state_nxt = last_return ? OUT : DRAIN;
            end
         end
         DRAIN: begin
            if (last_return) begin
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Job counters and result capture; data_ready outside FEED/DRAIN is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         k        <= '0;
         issued   <= '0;
         returned <= '0;
         out_psum <= '0;
      end else if (job_start) begin
         k        <= cfg_k;
         issued   <= '0;
         returned <= '0;
         if (cfg_k == '0) begin
            out_psum <= '0;
         end
      end else begin
         if (issue) begin
            issued <= issued + KW'(1);
         end
         if (dr_seen) begin
            returned <= returned + KW'(1);
         end
         if (last_return) begin
            out_psum <= pe_psum;
         end
      end
   end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Directed bench for pe_operand_feeder with a 2-cycle behavioural float-MAC PE.
module tb_pe_operand_feeder;
   localparam int unsigned KW = 16;
   localparam logic [31:0] F1   = 32'h3F80_0000;
   localparam logic [31:0] F2   = 32'h4000_0000;
   localparam logic [31:0] F3   = 32'h4040_0000;
   localparam logic [31:0] F4   = 32'h4080_0000;
   localparam logic [31:0] F5   = 32'h40A0_0000;
   localparam logic [31:0] F6   = 32'h40C0_0000;
   localparam logic [31:0] F8   = 32'h4100_0000;
   localparam logic [31:0] F21  = 32'h41A8_0000;
   localparam logic [31:0] F100 = 32'h42C8_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [KW-1:0] cfg_k = '0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_x = '0;
   logic [31:0]   in_w = '0;
   logic [31:0]   pe_x;
   logic [31:0]   pe_w;
   logic          pe_start;
   logic          pe_stall;
   logic          pe_data_ready;
   logic [31:0]   pe_psum;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_psum;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pe_operand_feeder #(.DEPTH(4), .KW(KW)) dut (
      .clk(clk), .rst(rst), .cfg_k(cfg_k), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
      .pe_x(pe_x), .pe_w(pe_w), .pe_start(pe_start), .pe_stall(pe_stall),
      .pe_data_ready(pe_data_ready), .pe_psum(pe_psum),
      .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
      .busy(busy), .done(done)
   );

   function automatic real sp2r(input logic [31:0] b);
      logic [63:0] d;
      if (b[30:0] == 31'd0) return 0.0;
      d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
   endfunction

   // Behavioural PE: product after 2 cycles, running float accumulation per job.
   logic stall_mode = 1'b0;
   logic stall_tgl  = 1'b0;
   logic dr_inj     = 1'b0;
   logic v1 = 1'b0;
   logic v2 = 1'b0;
   real  p1 = 0.0;
   real  p2 = 0.0;
   real  acc = 0.0;

   assign pe_stall      = stall_mode & stall_tgl;
   assign pe_data_ready = v2 | dr_inj;
   assign pe_psum       = dr_inj ? 32'hDEAD_BEEF : r2sp(acc + p2);

   always @(posedge clk) begin
      stall_tgl <= ~stall_tgl;
      if (rst) begin
         v1  <= 1'b0;
         v2  <= 1'b0;
         acc <= 0.0;
      end else begin
         v1 <= pe_start && !pe_stall;
         if (pe_start && !pe_stall) p1 <= sp2r(pe_x) * sp2r(pe_w);
         v2 <= v1;
         p2 <= p1;
         if (!busy) acc <= 0.0;
         else if (v2) acc <= acc + p2;
      end
   end

   // Job monitor: issued pairs in order, result pulses, done pulses, stall-hold errors.
   int          job_iss  = 0;
   int          job_dr   = 0;
   int          done_cnt = 0;
   int          hold_err = 0;
   logic        held = 1'b0;
   logic [31:0] hx = '0;
   logic [31:0] hw = '0;
   logic [63:0] iss_q [$];

   always @(posedge clk) begin
      if (rst) begin
         job_iss <= 0;
         job_dr  <= 0;
         iss_q.delete();
      end else if (start && !busy) begin
         job_iss <= 0;
         job_dr  <= 0;
         iss_q.delete();
      end else begin
         if (pe_start && !pe_stall) begin
            job_iss <= job_iss + 1;
            iss_q.push_back({pe_x, pe_w});
         end
         if (pe_data_ready && busy && !out_valid) job_dr <= job_dr + 1;
      end
      if (!rst && done) done_cnt <= done_cnt + 1;
      if (held && !rst && (!pe_start || pe_x !== hx || pe_w !== hw)) hold_err <= hold_err + 1;
      held <= pe_start && pe_stall && !rst;
      hx   <= pe_x;
      hw   <= pe_w;
   end

   task automatic push_one(input logic [31:0] x, input logic [31:0] w);
      in_valid = 1'b1;
      in_x     = x;
      in_w     = w;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start(input logic [KW-1:0] kk);
      cfg_k = kk;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_out(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (pe_start !== 1'b0) begin n_bad++; $display("FAIL reset_pe_start: got %b want 0", pe_start); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_psum !== 32'd0) begin n_bad++; $display("FAIL reset_out_psum: got %h want 0", out_psum); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_nominal();
      bit ok;
      int d0;
      stall_mode = 1'b1;
      out_ready  = 1'b1;
      repeat (4) push_one(F1, F2);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL nom_full: in_ready got %b want 0", in_ready); end
      d0 = done_cnt;
      pulse_start(KW'(4));
      n_cmp++; if (pe_start !== 1'b1) begin n_bad++; $display("FAIL nom_first_start: got %b want 1", pe_start); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy: got %b want 1", busy); end
      wait_out(60, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL nom_timeout: out_valid got 0 want 1 within 60 cycles"); end
      n_cmp++; if (out_psum !== F8) begin n_bad++; $display("FAIL nom_psum: got %h want %h", out_psum, F8); end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL nom_done: got %b want 1", done); end
      n_cmp++; if (job_iss !== 4) begin n_bad++; $display("FAIL nom_issues: got %0d want 4", job_iss); end
      n_cmp++; if (job_dr !== 4) begin n_bad++; $display("FAIL nom_results: got %0d want 4", job_dr); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL nom_busy_fall: got %b want 0", busy); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL nom_done_count: got %0d want 1", done_cnt - d0); end
      n_cmp++; if (hold_err !== 0) begin n_bad++; $display("FAIL nom_stall_hold: got %0d errors want 0", hold_err); end
      stall_mode = 1'b0;
   endtask

   task automatic test_starved();
      logic [31:0] xs [4];
      int          pushed;
      bit          got;
      logic [31:0] psum;
      int          iss_at;
      int          dr_at;
      xs = '{F1, F2, F3, F4};
      pushed = 0;
      got = 1'b0;
      psum = '0;
      iss_at = 0;
      dr_at = 0;
      out_ready = 1'b1;
      pulse_start(KW'(3));
      n_cmp++; if (pe_start !== 1'b0) begin n_bad++; $display("FAIL starve_bubble0: pe_start got %b want 0", pe_start); end
      for (int c = 0; c < 80 && !(got && pushed == 4); c++) begin
         if (c % 5 == 0 && pushed < 4) begin
            in_valid = 1'b1;
            in_x = xs[pushed];
            in_w = F1;
            pushed++;
         end else begin
            in_valid = 1'b0;
         end
         if (c == 1) begin
            n_cmp++; if (pe_start !== 1'b1) begin n_bad++; $display("FAIL starve_resume: pe_start got %b want 1", pe_start); end
         end
         if (c == 3 || c == 8) begin
            n_cmp++; if (pe_start !== 1'b0) begin n_bad++; $display("FAIL starve_bubble c=%0d: pe_start got %b want 0", c, pe_start); end
         end
         if (out_valid && !got) begin
            got = 1'b1;
            psum = out_psum;
            iss_at = job_iss;
            dr_at = job_dr;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL starve_timeout: out_valid got 0 want 1 within 80 cycles"); end
      n_cmp++; if (psum !== F6) begin n_bad++; $display("FAIL starve_psum: got %h want %h", psum, F6); end
      n_cmp++; if (iss_at !== 3) begin n_bad++; $display("FAIL starve_issues: got %0d want 3", iss_at); end
      n_cmp++; if (dr_at !== 3) begin n_bad++; $display("FAIL starve_results: got %0d want 3", dr_at); end
      n_cmp++; if (job_iss !== 3) begin n_bad++; $display("FAIL starve_no_overissue: got %0d want 3", job_iss); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL starve_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      bit ok;
      out_ready = 1'b0;
      pulse_start(KW'(1));
      wait_out(40, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: out_valid got 0 want 1 within 40 cycles"); end
      n_cmp++; if (out_psum !== F4) begin n_bad++; $display("FAIL bp_psum: got %h want %h", out_psum, F4); end
      for (int i = 0; i < 10; i++) begin
         cfg_k  = KW'(5);
         start  = (i % 3 == 0);
         dr_inj = (i % 2 == 1);
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1 || out_psum !== F4 || done !== 1'b0 || pe_start !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold cyc=%0d: valid=%b psum=%h done=%b pe_start=%b want 1 %h 0 0", i, out_valid, out_psum, done, pe_start, F4);
         end
      end
      start  = 1'b0;
      dr_inj = 1'b0;
      out_ready = 1'b1;
      #1;
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", done); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_idle: busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL bp_done_once: got %b want 0", done); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
   endtask

   task automatic test_zero_len();
      out_ready = 1'b0;
      push_one(F1, F1);
      push_one(F2, F1);
      pulse_start(KW'(0));
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL zero_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_psum !== 32'd0) begin n_bad++; $display("FAIL zero_psum: got %h want 0", out_psum); end
      n_cmp++; if (pe_start !== 1'b0) begin n_bad++; $display("FAIL zero_pe_start: got %b want 0", pe_start); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_idle: busy got %b want 0", busy); end
      n_cmp++; if (job_iss !== 0) begin n_bad++; $display("FAIL zero_issues: got %0d want 0", job_iss); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xs2 [2];
      logic [63:0] exp_q [6];
      int          idx;
      bit          got;
      bit          both_seen;
      logic [31:0] psum;
      xs2 = '{F5, F6};
      exp_q = '{{F1, F1}, {F2, F1}, {F3, F1}, {F4, F1}, {F5, F1}, {F6, F1}};
      idx = 0;
      got = 1'b0;
      both_seen = 1'b0;
      psum = '0;
      out_ready = 1'b1;
      push_one(F3, F1);
      push_one(F4, F1);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      push_one(F100, F1);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_drop: in_ready got %b want 0", in_ready); end
      pulse_start(KW'(6));
      for (int c = 0; c < 60 && !got; c++) begin
         if (idx < 2) begin
            in_valid = 1'b1;
            in_x = xs2[idx];
            in_w = F1;
            if (in_valid && in_ready && pe_start && !pe_stall) both_seen = 1'b1;
            if (in_ready) idx++;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            got = 1'b1;
            psum = out_psum;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout: out_valid got 0 want 1 within 60 cycles"); end
      n_cmp++; if (both_seen !== 1'b1) begin n_bad++; $display("FAIL b2b_push_pop: same-cycle push and issue got %b want 1", both_seen); end
      n_cmp++; if (psum !== F21) begin n_bad++; $display("FAIL b2b_psum: got %h want %h", psum, F21); end
      n_cmp++; if (iss_q.size() !== 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", iss_q.size()); end
      for (int i = 0; i < 6 && i < iss_q.size(); i++) begin
         n_cmp++;
         if (iss_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL b2b_order[%0d]: got %h want %h", i, iss_q[i], exp_q[i]);
         end
      end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_empty: in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      out_ready = 1'b1;
      repeat (4) push_one(F1, F1);
      pulse_start(KW'(4));
      for (int c = 0; c < 20 && job_iss != 2; c++) @(negedge clk);
      n_cmp++; if (job_iss !== 2) begin n_bad++; $display("FAIL rmid_reach: issues got %0d want 2", job_iss); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1 || pe_start !== 1'b0 || out_valid !== 1'b0 || out_psum !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_outputs: rdy=%b st=%b vld=%b psum=%h busy=%b done=%b want 1 0 0 0 0 0", in_ready, pe_start, out_valid, out_psum, busy, done);
      end
      push_one(F3, F1);
      push_one(F5, F1);
      pulse_start(KW'(2));
      wait_out(40, ok);
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rmid_timeout: out_valid got 0 want 1 within 40 cycles"); end
      n_cmp++; if (out_psum !== F8) begin n_bad++; $display("FAIL rmid_psum: got %h want %h", out_psum, F8); end
      n_cmp++; if (iss_q.size() !== 2) begin n_bad++; $display("FAIL rmid_count: got %0d want 2", iss_q.size()); end
      if (iss_q.size() == 2) begin
         n_cmp++; if (iss_q[0] !== {F3, F1}) begin n_bad++; $display("FAIL rmid_first: got %h want %h", iss_q[0], {F3, F1}); end
         n_cmp++; if (iss_q[1] !== {F5, F1}) begin n_bad++; $display("FAIL rmid_second: got %h want %h", iss_q[1], {F5, F1}); end
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_starved();
      test_backpressure();
      test_zero_len();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
